// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data SRAM arbiter.
// Both the top level and the round-robin picker import these.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 14;

    typedef enum logic [3:0] {
        IDLE,
        F_RD,
        F_CAP,
        S_LO,
        S_HI,
        S_DONE,
        L_LO,
        L_HI,
        L_CAP
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick between the fetch and data ports.
// On a tie the port that was not granted last wins.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic elig_if,
    input  logic elig_dm,
    input  logic last_gnt,
    output logic gnt_if,
    output logic gnt_dm,
    output logic next_gnt
);

    always_comb begin
        gnt_if   = 1'b0;
        gnt_dm   = 1'b0;
        next_gnt = last_gnt;
        if (elig_if && elig_dm) begin
            if (last_gnt == PORT_IF) begin
                gnt_dm = 1'b1;
            end else begin
                gnt_if = 1'b1;
            end
        end else if (elig_if) begin
            gnt_if = 1'b1;
        end else if (elig_dm) begin
            gnt_dm = 1'b1;
        end
        if (gnt_if) begin
            next_gnt = PORT_IF;
        end else if (gnt_dm) begin
            next_gnt = PORT_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide single-port SRAM between instruction fetch and a
// 16-bit load/store port; data accesses become two little-endian byte cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [7:0]        if_rdata,
    input  logic              dm_store,
    input  logic              dm_load,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [15:0]       dm_wdata,
    output logic              dm_done,
    output logic [15:0]       dm_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    input  logic [7:0]        sram_rdata
);

    state_e            state;
    port_e             last_gnt;
    logic              if_ack;
    logic              dm_ack;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic [7:0]        if_rdata_q;
    logic [15:0]       dm_rdata_q;

    logic              elig_if;
    logic              elig_dm;
    logic              gnt_if;
    logic              gnt_dm;
    logic              next_gnt;

    assign elig_if = if_req && !if_ack;
    assign elig_dm = (dm_store || dm_load) && !dm_ack;

    mem_arb_rr2 u_rr2 (
        .elig_if  (elig_if),
        .elig_dm  (elig_dm),
        .last_gnt (last_gnt),
        .gnt_if   (gnt_if),
        .gnt_dm   (gnt_dm),
        .next_gnt (next_gnt)
    );

    // The SRAM returns read data one cycle late, so the done cycle forwards
    // it directly; the holding registers take over from the next cycle.
    assign if_rdata = (state == F_CAP) ? sram_rdata : if_rdata_q;
    assign dm_rdata = (state == L_CAP) ? {sram_rdata, lo_q} : dm_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_gnt   <= PORT_IF;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            sram_ce <= 1'b0;
            sram_we <= 1'b0;

            // A request held past its done stays blocked until it drops.
            if (if_done) begin
                if_ack <= 1'b1;
            end else if (!if_req) begin
                if_ack <= 1'b0;
            end
            if (dm_done) begin
                dm_ack <= 1'b1;
            end else if (!dm_store && !dm_load) begin
                dm_ack <= 1'b0;
            end

            case (state)
                IDLE: begin
                    last_gnt <= port_e'(next_gnt);
                    if (gnt_if) begin
                        addr_q    <= if_addr;
                        sram_ce   <= 1'b1;
                        sram_addr <= if_addr;
                        state     <= F_RD;
                    end else if (gnt_dm) begin
                        addr_q    <= dm_addr;
                        sram_ce   <= 1'b1;
                        sram_addr <= dm_addr;
                        if (dm_store) begin
                            wdata_q    <= dm_wdata;
                            sram_we    <= 1'b1;
                            sram_wdata <= dm_wdata[7:0];
                            state      <= S_LO;
                        end else begin
                            state <= L_LO;
                        end
                    end
                end
                F_RD: begin
                    if_done <= 1'b1;
                    state   <= F_CAP;
                end
                F_CAP: begin
                    if_rdata_q <= sram_rdata;
                    state      <= IDLE;
                end
                S_LO: begin
                    sram_ce    <= 1'b1;
                    sram_we    <= 1'b1;
                    sram_addr  <= addr_q + 1'b1;
                    sram_wdata <= wdata_q[15:8];
                    state      <= S_HI;
                end
                S_HI: begin
                    dm_done <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= IDLE;
                end
                L_LO: begin
                    sram_ce   <= 1'b1;
                    sram_addr <= addr_q + 1'b1;
                    state     <= L_HI;
                end
                L_HI: begin
                    lo_q    <= sram_rdata;
                    dm_done <= 1'b1;
                    state   <= L_CAP;
                end
                L_CAP: begin
                    dm_rdata_q <= {sram_rdata, lo_q};
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-wide SRAM.
module tb_mem_port_arbiter;

    localparam int AW = 14;

    logic          clk;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [7:0]    if_rdata;
    logic          dm_store;
    logic          dm_load;
    logic [AW-1:0] dm_addr;
    logic [15:0]   dm_wdata;
    logic          dm_done;
    logic [15:0]   dm_rdata;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata;
    logic [7:0]    sram_rdata;

    logic [7:0]    mem [0:(1<<AW)-1];
    int            writes;
    int            errors;
    int            checks;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .dm_store   (dm_store),
        .dm_load    (dm_load),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_done    (dm_done),
        .dm_rdata   (dm_rdata),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: writes land on the edge, read data appears after it.
    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            mem[sram_addr] = sram_wdata;
            writes = writes + 1;
        end
        if (sram_ce && !sram_we) begin
            sram_rdata <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until the chosen done pulse; -1 if the budget runs out.
    task automatic wait_pulse(input bit on_if, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((on_if && if_done) || (!on_if && dm_done)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_done"}, 32'(if_done), 32'h0);
        check({tag, "_dm_done"}, 32'(dm_done), 32'h0);
        check({tag, "_ce"}, 32'(sram_ce), 32'h0);
        check({tag, "_we"}, 32'(sram_we), 32'h0);
        check({tag, "_addr"}, 32'(sram_addr), 32'h0);
        check({tag, "_wdata"}, 32'(sram_wdata), 32'h0);
        check({tag, "_if_rdata"}, 32'(if_rdata), 32'h0);
        check({tag, "_dm_rdata"}, 32'(dm_rdata), 32'h0);
    endtask

    initial begin
        int n;
        int w0;
        int dones;
        errors     = 0;
        checks     = 0;
        writes     = 0;
        reset_n    = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_store   = 1'b0;
        dm_load    = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        sram_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[14'h0100] = 8'hA5;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Store 0x1234 at 0x000A, cycle by cycle
        dm_store = 1'b1; dm_addr = 14'h000A; dm_wdata = 16'h1234;
        @(negedge clk);
        check("st_lo_ce", 32'(sram_ce), 32'h1);
        check("st_lo_we", 32'(sram_we), 32'h1);
        check("st_lo_addr", 32'(sram_addr), 32'h000A);
        check("st_lo_wdata", 32'(sram_wdata), 32'h34);
        @(negedge clk);
        check("st_hi_addr", 32'(sram_addr), 32'h000B);
        check("st_hi_wdata", 32'(sram_wdata), 32'h12);
        check("st_hi_nodone", 32'(dm_done), 32'h0);
        @(negedge clk);
        check("st_done", 32'(dm_done), 32'h1);
        check("st_mem_lo", 32'(mem[14'h000A]), 32'h34);
        check("st_mem_hi", 32'(mem[14'h000B]), 32'h12);
        dm_store = 1'b0;
        @(negedge clk);
        check("st_done_pulse", 32'(dm_done), 32'h0);
        check("st_idle_ce", 32'(sram_ce), 32'h0);
        check("st_addr_hold", 32'(sram_addr), 32'h000B);
        @(negedge clk);

        // Load back from 0x000A
        dm_load = 1'b1; dm_addr = 14'h000A;
        wait_pulse(1'b0, 8, n);
        check("ld_latency", 32'(n), 32'd3);
        check("ld_rdata", 32'(dm_rdata), 32'h1234);
        check("ld_rdata_lo", 32'(dm_rdata[7:0]), 32'h34);
        dm_load = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch alone
        if_req = 1'b1; if_addr = 14'h0100;
        wait_pulse(1'b1, 8, n);
        check("if_latency", 32'(n), 32'd2);
        check("if_rdata", 32'(if_rdata), 32'hA5);
        if_req = 1'b0;
        @(negedge clk);
        check("if_done_pulse", 32'(if_done), 32'h0);
        check("if_rdata_hold", 32'(if_rdata), 32'hA5);
        check("ld_rdata_hold", 32'(dm_rdata), 32'h1234);

        // Tie straight out of reset: data wins
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 14'h0100;
        dm_load = 1'b1; dm_addr = 14'h000A;
        @(negedge clk);
        check("tie1_data_first", 32'(sram_addr), 32'h000A);
        check("tie1_read", 32'(sram_we), 32'h0);
        if_req = 1'b0; dm_load = 1'b0;
        wait_pulse(1'b0, 8, n);
        check("tie1_ld_latency", 32'(n), 32'd2);
        check("tie1_ld_rdata", 32'(dm_rdata), 32'h1234);
        repeat (2) @(negedge clk);

        // Second tie: fetch wins, pending load follows
        if_req = 1'b1; if_addr = 14'h0100;
        dm_load = 1'b1; dm_addr = 14'h000A;
        @(negedge clk);
        check("tie2_fetch_first", 32'(sram_addr), 32'h0100);
        wait_pulse(1'b1, 8, n);
        check("tie2_if_latency", 32'(n), 32'd1);
        check("tie2_if_rdata", 32'(if_rdata), 32'hA5);
        check("tie2_dm_pending", 32'(dm_done), 32'h0);
        if_req = 1'b0;
        wait_pulse(1'b0, 8, n);
        check("tie2_dm_wait", 32'(n), 32'd4);
        check("tie2_ld_rdata", 32'(dm_rdata), 32'h1234);
        dm_load = 1'b0;
        repeat (2) @(negedge clk);

        // Store held high for 10 cycles: one done, two writes
        w0 = writes;
        dones = 0;
        dm_store = 1'b1; dm_addr = 14'h0020; dm_wdata = 16'h5566;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dm_done) dones++;
        end
        check("held_dones", 32'(dones), 32'd1);
        check("held_writes", 32'(writes - w0), 32'd2);
        dm_store = 1'b0;
        repeat (2) @(negedge clk);
        dm_store = 1'b1; dm_wdata = 16'h7788;
        wait_pulse(1'b0, 8, n);
        check("rearm_latency", 32'(n), 32'd3);
        check("rearm_mem_lo", 32'(mem[14'h0020]), 32'h88);
        check("rearm_mem_hi", 32'(mem[14'h0021]), 32'h77);
        dm_store = 1'b0;
        repeat (2) @(negedge clk);

        // Address wrap at the top of memory
        dm_store = 1'b1; dm_addr = 14'h3FFF; dm_wdata = 16'hBEEF;
        wait_pulse(1'b0, 8, n);
        check("wrap_st_latency", 32'(n), 32'd3);
        check("wrap_mem_top", 32'(mem[14'h3FFF]), 32'hEF);
        check("wrap_mem_zero", 32'(mem[14'h0000]), 32'hBE);
        dm_store = 1'b0;
        repeat (2) @(negedge clk);
        dm_load = 1'b1; dm_addr = 14'h3FFF;
        wait_pulse(1'b0, 8, n);
        check("wrap_ld_latency", 32'(n), 32'd3);
        check("wrap_ld_rdata", 32'(dm_rdata), 32'hBEEF);
        dm_load = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the high-byte write of a store
        dm_store = 1'b1; dm_addr = 14'h0040; dm_wdata = 16'hCAFE;
        repeat (2) @(negedge clk);
        check("abort_in_s_hi", 32'(sram_addr), 32'h0041);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        dm_store = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (dm_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_mem_lo", 32'(mem[14'h0040]), 32'hFE);
        check("abort_mem_hi", 32'(mem[14'h0041]), 32'h00);
        reset_n = 1'b1;
        @(negedge clk);
        dm_store = 1'b1;
        wait_pulse(1'b0, 8, n);
        check("post_rst_latency", 32'(n), 32'd3);
        check("post_rst_mem_hi", 32'(mem[14'h0041]), 32'hCA);
        dm_store = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port, byte-wide SRAM between the instruction-fetch port and the load/store data port. It serialises 16-bit data accesses into two little-endian byte cycles and returns one-cycle done pulses to each requester. It sits between the fetch/execute units and the SRAM interface, with one instance per SRAM.

## Interface
- ADDR_W, 14: byte address width; addresses wrap modulo 2^ADDR_W.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_done  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  8  fetched byte; held until the next fetch completes.
- dm_store  in  1  16-bit store request, level.
- dm_load  in  1  16-bit load request, level.
- dm_addr  in  ADDR_W  data byte address (low byte).
- dm_wdata  in  16  store data.
- dm_done  out  1  one-cycle pulse; completes either load or store.
- dm_rdata  out  16  load result {byte[addr+1], byte[addr]}; held until the next load completes.
- sram_ce  out  1  SRAM cycle enable.
- sram_we  out  1  write enable; qualified by sram_ce.
- sram_addr  out  ADDR_W  SRAM byte address.
- sram_wdata  out  8  SRAM write byte.
- sram_rdata  in  8  SRAM read byte; valid the cycle after a read cycle (ce=1, we=0).

## Operation
- States: IDLE, F_RD, F_CAP, S_LO, S_HI, S_DONE, L_LO, L_HI, L_CAP.
- IDLE samples requests and selects a port. On grant, it latches the address (and dm_wdata for a store) into internal registers. Requester inputs are ignored after the grant until the next IDLE.
- Arbitration, both ports eligible: grant goes to the port not granted last (2-way round robin). last_gnt resets to "fetch", so data wins the first tie.
- dm_store and dm_load both high: treated as a store; the load is not serviced.
- Fetch path: F_RD drives ce=1, we=0, addr=A. F_CAP captures sram_rdata into if_rdata, pulses if_done, then goes to IDLE.
- Store path:
  - S_LO: ce=1, we=1, addr=A, wdata=W[7:0].
  - S_HI: ce=1, we=1, addr=A+1 (wraps 0x3FFF→0x0000), wdata=W[15:8].
  - S_DONE: pulses dm_done, then IDLE.
- Load path:
  - L_LO: read A.
  - L_HI: read A+1; capture the low byte.
  - L_CAP: capture the high byte, update dm_rdata, pulse dm_done, then IDLE.
- Re-arm rule: each port has an ack flag, set when its done pulses and cleared when its request input(s) are low. A port is eligible only when its request is high and its ack flag is clear. A request held high after done is therefore never serviced twice.
- SRAM outputs in non-access states: sram_ce=0, sram_we=0; sram_addr and sram_wdata hold their last value.

## Timing
- Reset values:
  - State IDLE; last_gnt = fetch; ack flags 0.
  - if_done, dm_done, sram_ce, sram_we all 0.
  - if_rdata, dm_rdata, sram_addr, sram_wdata all 0.
- Latencies, measured from the IDLE cycle in which the request is sampled (cycle 0) to the done pulse:
  - Fetch: done in cycle 2.
  - Store: done in cycle 3.
  - Load: done in cycle 3.
- Back-to-back: after a done, the arbiter is in IDLE on the next cycle. With both ports continuously re-requesting, throughput is one fetch then one data access, alternating.
- A losing request stays pending. Maximum wait is one data operation (4 cycles including IDLE).
- SRAM outputs are decoded from the registered state and captured registers only; no combinational path from requester inputs to sram_*.
- Reset asserted mid-operation: immediate return to reset values. Any partially completed store (low byte written, high byte not written) is left as-is. No done pulse is issued for an aborted operation.

## Structure
- Package mem_arb_pkg holds:
  - the state enum typedef;
  - the ADDR_W default localparam;
  - the port-id enum (PORT_IF, PORT_DM) used for last_gnt.
- Sub-module mem_arb_rr2: 2-way round-robin pick. Inputs are the two eligibility bits and last_gnt; outputs are the grant and the next last_gnt. It is combinational and used only in IDLE.
- Everything else (FSM, capture registers, ack flags) stays in mem_port_arbiter.

## Test plan
- Store then load:
  - dm_store with addr 0x000A, wdata 0x1234 → SRAM writes 0x34@0x000A then 0x12@0x000B; dm_done in cycle 3.
  - A subsequent dm_load at 0x000A → dm_rdata=0x1234, dm_rdata[7:0]=0x34.
- Fetch alone: preload 0xA5@0x0100; if_req with if_addr 0x0100 → if_done in cycle 2, if_rdata=0xA5.
- Simultaneous requests from reset: if_req and dm_load sampled in the same cycle → data granted first, then fetch. Repeat both → fetch granted first (alternation).
- Held request: dm_store held high for 10 cycles → exactly one dm_done and exactly two SRAM writes. Dropping dm_store and raising it again → a second store is serviced.
- Wrap: store 0xBEEF at 0x3FFF → 0xEF@0x3FFF, 0xBE@0x0000; load at 0x3FFF returns 0xBEEF.
- Reset mid-store: reset_n low during S_HI → all outputs go to reset values immediately; no dm_done; the next store after reset completes normally.
